display_cfg_sequencer: RTL
==========================

Name: display_cfg_sequencer

Overview:
- AXI4-Lite master that programs the display-control register bank (NUM_REGS 32-bit registers at BASE_ADDR + 4*i) from a latched configuration vector.
- Optionally reads every register back and compares it against the written value.
- Sits between the system control logic and the display-control AXI4-Lite slave, replacing software-driven bring-up writes.
- Reports busy/done/error status, including the failing register index and cause.

Parameters:
- NUM_REGS, 4, registers programmed per sequence (1..16).
- BASE_ADDR, 32'h0000_0000, byte address of register 0.
- ADDR_WIDTH, 32, AXI address width.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sequence
- verify_en  in  1  sampled with start; 1 = readback-compare pass after the writes
- cfg_data  in  NUM_REGS*32  register i value at bits [32*i+31:32*i], latched on accepted start
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse when the sequence ends (success or error)
- error  out  1  sticky; cleared on next accepted start
- err_code  out  2  0 none, 1 BRESP not OKAY, 2 RRESP not OKAY, 3 readback mismatch
- err_index  out  4  register index of first error
- M_AXI_AWADDR  out  ADDR_WIDTH; M_AXI_AWPROT out 3 (always 0); M_AXI_AWVALID out 1; M_AXI_AWREADY in 1
- M_AXI_WDATA  out  32; M_AXI_WSTRB out 4 (always 4'hF); M_AXI_WVALID out 1; M_AXI_WREADY in 1
- M_AXI_BRESP  in  2; M_AXI_BVALID in 1; M_AXI_BREADY out 1
- M_AXI_ARADDR  out  ADDR_WIDTH; M_AXI_ARPROT out 3 (always 0); M_AXI_ARVALID out 1; M_AXI_ARREADY in 1
- M_AXI_RDATA  in  32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1

Behaviour:
- Reset (ARESETN low, async): state IDLE; all VALID/READY outputs 0; busy, done, error 0; err_code 0; err_index 0; address/data outputs 0; index counter 0. Reset mid-transaction abandons the transaction immediately.
- FSM states:
  - IDLE: start=1 latches cfg_data and verify_en, clears error/err_code/err_index, sets idx=0, busy=1, goes to WR.
  - WR: AWVALID and WVALID asserted together from the first WR cycle. AWADDR = BASE_ADDR + 4*idx; WDATA = cfg word idx. Each channel drops its VALID the cycle after its own handshake; AW and W may complete in either order or the same cycle. When both are done, go to WRESP.
  - WRESP: BREADY=1. On BVALID, BRESP != 0 sets err_code=1, err_index=idx and goes to FIN. Otherwise: if idx < NUM_REGS-1, increment idx and return to WR; else if verify_en, idx=0 and go to RD; else go to FIN.
  - RD: ARVALID=1, ARADDR = BASE_ADDR + 4*idx; go to RDATA after the ARREADY handshake.
  - RDATA: RREADY=1. On RVALID, RRESP != 0 gives err_code=2; else RDATA != cfg word idx gives err_code=3. Either error sets err_index=idx and goes to FIN. Otherwise advance idx or go to FIN after the last register.
  - FIN: done=1 for exactly one cycle, busy=0, error=(err_code!=0); return to IDLE.
- Timing and ordering:
  - VALID is never deasserted before its handshake, and address/data are held stable while VALID is high.
  - Exactly one outstanding transaction; the next AW/AR is issued no earlier than the cycle after the previous B/R handshake.
  - Minimum latency with always-ready slave: 2 cycles per write (WR, WRESP), 2 cycles per read, plus 1 cycle for FIN. With NUM_REGS=4 and verify_en=0, done is asserted 9 cycles after the start cycle.
- Boundary cases:
  - start while busy is ignored (no relatch, no effect on the sequence in progress).
  - start coincident with done/FIN is ignored; accepted from the next cycle in IDLE.
  - NUM_REGS=1 runs a single write (and read).
  - idx counter is 4 bits; no wrap occurs for NUM_REGS ≤ 16.
  - Address arithmetic is modulo 2^ADDR_WIDTH.

Test Plan:
- Always-ready AXI-Lite slave memory, cfg = {4,3,2,1}, verify_en=1 -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match; done pulse, error=0, busy low after done.
- Slave with AWREADY delayed 3 cycles and WREADY immediate (then swapped) -> exactly one AW and one W handshake per register; AWADDR/WDATA stable while VALID; memory contents correct.
- Slave returns BRESP=2'b10 on register 2 -> no AW issued for register 3; done pulse; error=1, err_code=1, err_index=2.
- Slave memory corrupts register 1 (stores 0xDEAD) with verify_en=1 -> err_code=3, err_index=1, no read of register 2.
- start re-pulsed mid-sequence with different cfg_data -> ignored; original values written; next start after done clears error and runs again.
- ARESETN low during WRESP -> all VALID/READY, busy, done drop asynchronously; after release, a new start completes normally.

Source files
------------

// File: rtl/display_cfg_sequencer.sv
// display_cfg_sequencer: AXI4-Lite master that writes a latched config vector to a register bank and optionally reads it back to verify
// Ports: ACLK/ARESETN clock and async active-low reset; start/verify_en/cfg_data request a sequence;
//   busy/done/error/err_code/err_index report status; M_AXI_* is the AXI4-Lite master interface.
module display_cfg_sequencer #(
  parameter int NUM_REGS = 4,
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    start,
  input  logic                    verify_en,
  input  logic [NUM_REGS*32-1:0]  cfg_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [3:0]              err_index,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [31:0]             M_AXI_WDATA,
  output logic [3:0]              M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [31:0]             M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);
  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, FIN} state_t;
  localparam logic [3:0] LAST = 4'(NUM_REGS - 1);
  state_t state;
  logic [3:0] idx;
  logic [3:0] nxt;
  logic [NUM_REGS*32-1:0] cfg;
  logic verify;
  logic [31:0] cur_word;
  logic [31:0] nxt_word;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  assign nxt = idx + 4'd1;
  assign cur_word = 32'(cfg >> {idx, 5'd0});
  assign nxt_word = 32'(cfg >> {nxt, 5'd0});
  assign nxt_addr = BASE_ADDR + ADDR_WIDTH'({nxt, 2'b00});
  assign M_AXI_AWPROT = 3'd0;
  assign M_AXI_ARPROT = 3'd0;
  assign M_AXI_WSTRB = 4'hF;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= IDLE;
      idx <= '0;
      cfg <= '0;
      verify <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= 2'd0;
      err_index <= 4'd0;
      M_AXI_AWADDR <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA <= '0;
      M_AXI_WVALID <= 1'b0;
      M_AXI_BREADY <= 1'b0;
      M_AXI_ARADDR <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cfg <= cfg_data;
          verify <= verify_en;
          error <= 1'b0;
          err_code <= 2'd0;
          err_index <= 4'd0;
          idx <= 4'd0;
          busy <= 1'b1;
          M_AXI_AWADDR <= BASE_ADDR;
          M_AXI_WDATA <= cfg_data[31:0];
          M_AXI_AWVALID <= 1'b1;
          M_AXI_WVALID <= 1'b1;
          state <= WR;
        end
        WR: begin
          // a dropped VALID marks that channel's handshake as already done
          M_AXI_AWVALID <= M_AXI_AWVALID && !M_AXI_AWREADY;
          M_AXI_WVALID <= M_AXI_WVALID && !M_AXI_WREADY;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            M_AXI_BREADY <= 1'b1;
            state <= WRESP;
          end
        end
        WRESP: if (M_AXI_BVALID) begin
          M_AXI_BREADY <= 1'b0;
          if (M_AXI_BRESP != 2'b00) begin
            err_code <= 2'd1;
            err_index <= idx;
            error <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
            state <= FIN;
          end else if (idx < LAST) begin
            idx <= nxt;
            M_AXI_AWADDR <= nxt_addr;
            M_AXI_WDATA <= nxt_word;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID <= 1'b1;
            state <= WR;
          end else if (verify) begin
            idx <= 4'd0;
            M_AXI_ARADDR <= BASE_ADDR;
            M_AXI_ARVALID <= 1'b1;
            state <= RD;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= FIN;
          end
        end
        RD: if (M_AXI_ARREADY) begin
          M_AXI_ARVALID <= 1'b0;
          M_AXI_RREADY <= 1'b1;
          state <= RDATA;
        end
        RDATA: if (M_AXI_RVALID) begin
          M_AXI_RREADY <= 1'b0;
          if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != cur_word) begin
            err_code <= (M_AXI_RRESP != 2'b00) ? 2'd2 : 2'd3;
            err_index <= idx;
            error <= 1'b1;
            busy <= 1'b0;
            done <= 1'b1;
            state <= FIN;
          end else if (idx < LAST) begin
            idx <= nxt;
            M_AXI_ARADDR <= nxt_addr;
            M_AXI_ARVALID <= 1'b1;
            state <= RD;
          end else begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= FIN;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
